logic_bist: RTL and testbench

- Hardware built-in self-test controller for the 8-bit logic unit (AND/OR/XOR/NOR slice of the ALU).
- On a start request it latches one operand pair and drives it into the logic unit, stepping Logic_Sel through all four operations.
- It samples Logic_Out for each operation, compares it against an internal golden model, and reports pass/fail, a per-op fail mask and an error count.
- Sits beside logic_unit and owns its inputs during test. A system-level mux selects between BIST and normal datapath; the mux is outside this block.

---
 rtl/logic_pkg.sv | 18 +
 rtl/logic_bist_if.sv | 26 ++
 rtl/logic_golden.sv | 25 ++
 rtl/logic_bist.sv | 131 +++++++++++++
 tb/tb_logic_bist.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
// Shared encodings for the logic-unit BIST and its golden model.
// Imported by the checker, the golden model and the interface users.
package logic_pkg;

    localparam int NUM_OPS = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } bist_state_e;

endpackage

// File: rtl/logic_bist_if.sv
// Operand/select/result bundle between the BIST and the logic unit.
// The BIST is the master; the logic unit answers combinationally.
interface logic_bist_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] Logic_A;
    logic [WIDTH-1:0] Logic_B;
    logic [1:0]       Logic_Sel;
    logic [WIDTH-1:0] Logic_Out;

    modport master (
        output Logic_A,
        output Logic_B,
        output Logic_Sel,
        input  Logic_Out
    );

    modport slave (
        input  Logic_A,
        input  Logic_B,
        input  Logic_Sel,
        output Logic_Out
    );

endinterface

// File: rtl/logic_golden.sv
// Combinational reference for the AND/OR/XOR/NOR logic unit.
// Kept free of state so the ALU-level checker can reuse it.
module logic_golden
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_bist.sv
// Self-test sequencer: latches one operand pair, sweeps all four ops
// through the logic unit and scores each result against logic_golden.
module logic_bist
    import logic_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    logic_bist_if.master     lu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [2:0]       err_count
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       err_q, err_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] gold;
    logic             mismatch;
    logic             window_end;

    logic_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (gold)
    );

    assign mismatch   = (lu.Logic_Out != gold);
    assign window_end = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    a_d     = A_in;
                    b_d     = B_in;
                    sel_d   = OP_AND;
                    cnt_d   = '0;
                    mask_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                if (window_end) begin
                    cnt_d = '0;
                    if (mismatch) begin
                        mask_d[sel_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    // pass is fixed on the edge into DONE so it is
                    // already valid during the done pulse
                    if (sel_q == OP_NOR) begin
                        state_d = DONE;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign lu.Logic_A   = a_q;
    assign lu.Logic_B   = b_q;
    assign lu.Logic_Sel = sel_q;

    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_logic_bist.sv
// Scoreboard bench for logic_bist at HOLD_CYCLES 2, 3 and 1.
// Stimulus queues expected sweeps; a negedge monitor scores them.
module tb_logic_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [7:0] A_in = '0;
    logic [7:0] B_in = '0;
    logic fault = 1'b0;

    logic [2:0] busy_w, done_w, pass_w;
    logic [3:0] mask_w [3];
    logic [2:0] err_w [3];
    logic [7:0] la [3];
    logic [7:0] lb [3];
    logic [1:0] ls [3];
    logic [7:0] lo [3];

    int hold [3] = '{2, 3, 1};

    always #5 clk = ~clk;

    logic_bist_if #(.WIDTH(8)) if0 ();
    logic_bist_if #(.WIDTH(8)) if1 ();
    logic_bist_if #(.WIDTH(8)) if2 ();

    logic_bist #(.WIDTH(8), .HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .A_in(A_in), .B_in(B_in), .lu(if0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_mask(mask_w[0]), .err_count(err_w[0])
    );

    logic_bist #(.WIDTH(8), .HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .A_in(A_in), .B_in(B_in), .lu(if1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_mask(mask_w[1]), .err_count(err_w[1])
    );

    logic_bist #(.WIDTH(8), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .A_in(A_in), .B_in(B_in), .lu(if2),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_mask(mask_w[2]), .err_count(err_w[2])
    );

    // Stand-in logic unit; fault forces bit0 stuck at 0
    function automatic logic [7:0] unit(
        input logic [7:0] a, input logic [7:0] b,
        input logic [1:0] s, input logic f
    );
        logic [7:0] r;
        case (s)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: r = a ^ b;
            default: r = ~(a | b);
        endcase
        return f ? (r & 8'hFE) : r;
    endfunction

    assign if0.Logic_Out = unit(if0.Logic_A, if0.Logic_B, if0.Logic_Sel, fault);
    assign if1.Logic_Out = unit(if1.Logic_A, if1.Logic_B, if1.Logic_Sel, fault);
    assign if2.Logic_Out = unit(if2.Logic_A, if2.Logic_B, if2.Logic_Sel, fault);

    assign la[0] = if0.Logic_A;  assign la[1] = if1.Logic_A;  assign la[2] = if2.Logic_A;
    assign lb[0] = if0.Logic_B;  assign lb[1] = if1.Logic_B;  assign lb[2] = if2.Logic_B;
    assign ls[0] = if0.Logic_Sel; assign ls[1] = if1.Logic_Sel; assign ls[2] = if2.Logic_Sel;
    assign lo[0] = if0.Logic_Out; assign lo[1] = if1.Logic_Out; assign lo[2] = if2.Logic_Out;

    typedef struct {
        int         inst;
        logic [7:0] a;
        logic [7:0] b;
        logic       pass;
        logic [3:0] mask;
        logic [2:0] err;
        int         lat;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] samp_q [$];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    int         cyc [3]    = '{0, 0, 0};
    int         run [3]    = '{0, 0, 0};
    logic       busy_p [3] = '{1'b0, 1'b0, 1'b0};
    logic [1:0] sel_p [3]  = '{2'b00, 2'b00, 2'b00};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                busy_p[i] = 1'b0;
                run[i]    = 0;
                continue;
            end
            if (busy_w[i]) begin
                if (!busy_p[i]) begin
                    cyc[i] = 0;
                    run[i] = 1;
                    chk("sel_first", ls[i], 2'b00);
                end else begin
                    cyc[i]++;
                    if (ls[i] == sel_p[i]) begin
                        run[i]++;
                    end else begin
                        chk("hold_len", run[i], hold[i]);
                        chk("sel_step", ls[i], 2'(sel_p[i] + 2'd1));
                        run[i] = 1;
                    end
                end
                if (exp_q.size() > 0) begin
                    chk("logic_a", la[i], exp_q[0].a);
                    chk("logic_b", lb[i], exp_q[0].b);
                end
                if (run[i] == hold[i]) begin
                    if (samp_q.size() > 0) chk("sample", lo[i], samp_q.pop_front());
                    else chk("sample_unexpected", 1, 0);
                end
            end
            if (done_w[i]) begin
                cyc[i]++;
                chk("hold_len_last", run[i], hold[i]);
                chk("sel_last", ls[i], 2'b11);
                chk("busy_in_done", busy_w[i], 1'b0);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_inst", i, e.inst);
                    chk("done_latency", cyc[i], e.lat);
                    chk("pass", pass_w[i], e.pass);
                    chk("fail_mask", mask_w[i], e.mask);
                    chk("err_count", err_w[i], e.err);
                end else begin
                    chk("done_unexpected", 1, 0);
                end
            end
            busy_p[i] = busy_w[i];
            sel_p[i]  = ls[i];
        end
    end

    task automatic push_sweep(
        input int inst, input logic [7:0] a, input logic [7:0] b,
        input logic [31:0] s, input logic p,
        input logic [3:0] m, input logic [2:0] e
    );
        exp_t x;
        x.inst = inst; x.a = a; x.b = b;
        x.pass = p; x.mask = m; x.err = e;
        x.lat = 4 * hold[inst];
        exp_q.push_back(x);
        samp_q.push_back(s[31:24]);
        samp_q.push_back(s[23:16]);
        samp_q.push_back(s[15:8]);
        samp_q.push_back(s[7:0]);
    endtask

    task automatic drive_start(input int inst, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A_in = a;
        B_in = b;
        start[inst] = 1'b1;
        @(posedge clk);
        #1 start[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_w[inst]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep(
        input int inst, input logic [7:0] a, input logic [7:0] b,
        input logic [31:0] s, input logic p,
        input logic [3:0] m, input logic [2:0] e
    );
        push_sweep(inst, a, b, s, p, m, e);
        drive_start(inst, a, b);
        wait_done(inst);
    endtask

    task automatic chk_zero();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy_w[i], 1'b0);
            chk("rst_done", done_w[i], 1'b0);
            chk("rst_pass", pass_w[i], 1'b0);
            chk("rst_mask", mask_w[i], 4'h0);
            chk("rst_err", err_w[i], 3'h0);
            chk("rst_a", la[i], 8'h00);
            chk("rst_b", lb[i], 8'h00);
            chk("rst_sel", ls[i], 2'b00);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(0, 8'h0A, 8'h02, 32'h020A08F5, 1'b1, 4'b0000, 3'd0);
        sweep(0, 8'hF6, 8'h0A, 32'h02FEFC01, 1'b1, 4'b0000, 3'd0);

        fault = 1'b1;
        sweep(0, 8'h0A, 8'h02, 32'h020A08F4, 1'b0, 4'b1000, 3'd1);
        fault = 1'b0;

        // start mid-sweep with new operands must be ignored
        push_sweep(0, 8'h0A, 8'h02, 32'h020A08F5, 1'b1, 4'b0000, 3'd0);
        drive_start(0, 8'h0A, 8'h02);
        repeat (3) @(negedge clk);
        A_in = 8'hFF;
        B_in = 8'hFF;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        chk("ign_busy", busy_w[0], 1'b1);
        chk("ign_logic_a", la[0], 8'h0A);
        wait_done(0);
        repeat (6) @(negedge clk);

        // reset at cycle 5 aborts; only two windows complete
        samp_q.push_back(8'h02);
        samp_q.push_back(8'h0A);
        drive_start(0, 8'h0A, 8'h02);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero();
        chk("abort_samples", samp_q.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_w[0], 1'b0);
        sweep(0, 8'hF6, 8'h0A, 32'h02FEFC01, 1'b1, 4'b0000, 3'd0);

        sweep(1, 8'h0A, 8'h02, 32'h020A08F5, 1'b1, 4'b0000, 3'd0);
        sweep(2, 8'h0A, 8'h02, 32'h020A08F5, 1'b1, 4'b0000, 3'd0);

        repeat (10) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("samp_q_empty", samp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
